alarm_ctrl: RTL and testbench

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/alarm_pkg.sv | 19 +
 rtl/alarm_ctrl_if.sv | 33 +++
 rtl/bcd_time_counter.sv | 73 +++++++
 rtl/alarm_ctrl.sv | 130 +++++++++++++
 tb/tb_alarm_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_pkg.sv
// Alarm clock controller: shared types and constants.
// State encoding, BCD digit limits and parameter defaults.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] MIN_TENS_MAX = 4'd5;
  localparam logic [7:0] HOUR_MAX     = 8'd23;

  localparam logic [31:0] DEF_TICKS_PER_MIN = 32'd60000000;
  localparam logic [5:0]  DEF_SNOOZE_MIN    = 6'd5;
  localparam logic [5:0]  DEF_RING_MIN      = 6'd10;

endpackage

// File: rtl/alarm_ctrl_if.sv
// Alarm clock controller: command and status bundle.
// master drives commands, slave is the controller.
interface alarm_ctrl_if;
  import alarm_pkg::*;

  logic [31:0] set_value;
  logic        load_time;
  logic        load_alarm;
  logic        alarm_enable;
  logic        snooze;
  logic        stop_alarm;
  logic [31:0] current_time;
  logic [31:0] alarm_time;
  logic        one_minute;
  logic        sound_alarm;
  logic        snooze_active;
  logic [1:0]  state;

  modport master (
    output set_value, load_time, load_alarm,
    output alarm_enable, snooze, stop_alarm,
    input  current_time, alarm_time, one_minute,
    input  sound_alarm, snooze_active, state
  );

  modport slave (
    input  set_value, load_time, load_alarm,
    input  alarm_enable, snooze, stop_alarm,
    output current_time, alarm_time, one_minute,
    output sound_alarm, snooze_active, state
  );

endinterface

// File: rtl/bcd_time_counter.sv
// Packed-BCD HH:MM register with validated load and
// minute increment (carry through M0, M1, hours, midnight).
module bcd_time_counter
  import alarm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] value,
  output logic [31:0] next_val,
  output logic        load_ok
);

  logic [7:0] hours;
  logic       valid;

  assign hours = 8'(load_val[27:24]) * 8'd10
               + 8'(load_val[19:16]);

  always_comb begin
    valid = 1'b1;
    if ((load_val & 32'hF0F0_F0F0) != 32'h0)
      valid = 1'b0;
    if (load_val[3:0] > DIGIT_MAX)
      valid = 1'b0;
    if (load_val[11:8] > MIN_TENS_MAX)
      valid = 1'b0;
    if (load_val[19:16] > DIGIT_MAX)
      valid = 1'b0;
    if (load_val[27:24] > DIGIT_MAX)
      valid = 1'b0;
    if (hours > HOUR_MAX)
      valid = 1'b0;
  end

  assign load_ok = load & valid;

  always_comb begin
    next_val = value;
    if (value[3:0] != DIGIT_MAX) begin
      next_val[3:0] = value[3:0] + 4'd1;
    end else begin
      next_val[3:0] = 4'd0;
      if (value[11:8] != MIN_TENS_MAX) begin
        next_val[11:8] = value[11:8] + 4'd1;
      end else begin
        next_val[11:8] = 4'd0;
        if (value[27:24] == 4'd2 &&
            value[19:16] == 4'd3) begin
          next_val[27:24] = 4'd0;
          next_val[19:16] = 4'd0;
        end else if (value[19:16] == DIGIT_MAX) begin
          next_val[19:16] = 4'd0;
          next_val[27:24] = value[27:24] + 4'd1;
        end else begin
          next_val[19:16] = value[19:16] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      value <= 32'h0;
    else if (load_ok)
      value <= load_val;
    else if (inc)
      value <= next_val;
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: minute prescaler, time/alarm
// registers and the IDLE/RINGING/SNOOZE state machine.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter logic [31:0] TICKS_PER_MIN = DEF_TICKS_PER_MIN,
  parameter logic [5:0]  SNOOZE_MIN    = DEF_SNOOZE_MIN,
  parameter logic [5:0]  RING_MIN      = DEF_RING_MIN
) (
  input logic         clk,
  input logic         rst_n,
  alarm_ctrl_if.slave bus
);

  logic [31:0] presc;
  logic        wrap;
  logic        tick;
  logic        tload_ok;
  logic        aload_ok;
  logic        match;
  logic        minute_q;
  logic [31:0] cur_time;
  logic [31:0] nxt_time;
  logic [31:0] alm_time;
  logic [31:0] alm_next;
  state_t      state_q, state_d;
  logic [5:0]  ring_q, ring_d;
  logic [5:0]  snz_q, snz_d;

  assign wrap = (presc == TICKS_PER_MIN - 32'd1);
  // a valid time load restarts the minute, so it masks the tick
  assign tick = wrap & ~tload_ok;

  bcd_time_counter u_time (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (tick),
    .load     (bus.load_time),
    .load_val (bus.set_value),
    .value    (cur_time),
    .next_val (nxt_time),
    .load_ok  (tload_ok)
  );

  bcd_time_counter u_alarm (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (1'b0),
    .load     (bus.load_alarm),
    .load_val (bus.set_value),
    .value    (alm_time),
    .next_val (alm_next),
    .load_ok  (aload_ok)
  );

  assign match = tick & (nxt_time == alm_time);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= 32'd0;
      minute_q <= 1'b0;
    end else begin
      presc    <= (tload_ok | wrap) ? 32'd0
                                    : presc + 32'd1;
      minute_q <= tick;
    end
  end

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    if (!bus.alarm_enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (match) begin
            state_d = RINGING;
            ring_d  = RING_MIN;
          end
        end
        RINGING: begin
          if (bus.stop_alarm) begin
            state_d = IDLE;
          end else if (bus.snooze) begin
            state_d = SNOOZE;
            snz_d   = SNOOZE_MIN;
          end else if (tick) begin
            ring_d = ring_q - 6'd1;
            if (ring_q == 6'd1)
              state_d = IDLE;
          end
        end
        SNOOZE: begin
          if (bus.stop_alarm) begin
            state_d = IDLE;
          end else if (tick) begin
            snz_d = snz_q - 6'd1;
            if (snz_q == 6'd1) begin
              state_d = RINGING;
              ring_d  = RING_MIN;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ring_q  <= 6'd0;
      snz_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      snz_q   <= snz_d;
    end
  end

  assign bus.current_time  = cur_time;
  assign bus.alarm_time    = alm_time;
  assign bus.one_minute    = minute_q;
  assign bus.state         = state_q;
  assign bus.sound_alarm   = (state_q == RINGING);
  assign bus.snooze_active = (state_q == SNOOZE);

endmodule

// File: tb/tb_alarm_ctrl.sv
// Alarm controller bench: directed scenarios plus random
// commands against a minutes-since-midnight model.
module tb_alarm_ctrl;

  localparam int T  = 4;
  localparam int SN = 2;
  localparam int RG = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alarm_ctrl_if bus ();

  alarm_ctrl #(
    .TICKS_PER_MIN (32'd4),
    .SNOOZE_MIN    (6'd2),
    .RING_MIN      (6'd3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int m_min, m_alm, m_pre, m_st, m_sn, m_rg;
  bit m_om;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(int m);
    int h, mm;
    h  = m / 60;
    mm = m % 60;
    return {4'h0, 4'(h / 10), 4'h0, 4'(h % 10),
            4'h0, 4'(mm / 10), 4'h0, 4'(mm % 10)};
  endfunction

  // minutes since midnight, or -1 when not a legal time
  function automatic int from_bcd(logic [31:0] v);
    int d [4];
    int h;
    for (int i = 0; i < 4; i++) begin
      d[i] = int'(v[8*i +: 4]);
      if (v[8*i+4 +: 4] != 4'h0 || d[i] > 9)
        return -1;
    end
    if (d[1] > 5) return -1;
    h = d[3] * 10 + d[2];
    if (h > 23) return -1;
    return h * 60 + d[1] * 10 + d[0];
  endfunction

  task automatic model_reset();
    m_min = 0; m_alm = 0; m_pre = 0;
    m_st = 0; m_sn = 0; m_rg = 0; m_om = 0;
  endtask

  task automatic model_edge();
    int tv, nm, old_alm;
    bit lt, la, wrap, tk;
    tv      = from_bcd(bus.set_value);
    lt      = bus.load_time && tv >= 0;
    la      = bus.load_alarm && tv >= 0;
    wrap    = (m_pre == T - 1);
    tk      = wrap && !lt;
    nm      = (m_min + 1) % 1440;
    old_alm = m_alm;
    m_om    = tk;
    m_pre   = (lt || wrap) ? 0 : m_pre + 1;
    if (!bus.alarm_enable) begin
      m_st = 0;
    end else if (m_st == 0) begin
      if (tk && nm == old_alm) begin
        m_st = 1; m_rg = RG;
      end
    end else if (m_st == 1) begin
      if (bus.stop_alarm) m_st = 0;
      else if (bus.snooze) begin
        m_st = 2; m_sn = SN;
      end else if (tk) begin
        m_rg--;
        if (m_rg == 0) m_st = 0;
      end
    end else begin
      if (bus.stop_alarm) m_st = 0;
      else if (tk) begin
        m_sn--;
        if (m_sn == 0) begin
          m_st = 1; m_rg = RG;
        end
      end
    end
    if (lt) m_min = tv;
    else if (tk) m_min = nm;
    if (la) m_alm = tv;
  endtask

  task automatic check_all();
    check("cur", bus.current_time, to_bcd(m_min));
    check("alm", bus.alarm_time, to_bcd(m_alm));
    check("one_minute", bus.one_minute, m_om);
    check("state", bus.state, m_st);
    check("sound", bus.sound_alarm, m_st == 1);
    check("snz_act", bus.snooze_active, m_st == 2);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    bus.load_time  = 1'b0;
    bus.load_alarm = 1'b0;
    bus.snooze     = 1'b0;
    bus.stop_alarm = 1'b0;
  endtask

  task automatic load_t(logic [31:0] v);
    bus.set_value = v;
    bus.load_time = 1'b1;
    step();
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] v;
    int j;
    if ($urandom_range(0, 1) == 1)
      v = to_bcd((m_alm + 1439) % 1440);
    else
      v = to_bcd($urandom_range(0, 1439));
    if ($urandom_range(0, 99) < 15) begin
      j = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: v[8*j +: 4] = 4'($urandom_range(10, 15));
        1: v[11:8] = 4'($urandom_range(6, 9));
        2: begin
          v[27:24] = 4'd2;
          v[19:16] = 4'($urandom_range(4, 9));
        end
        default: v[8*j+4 +: 4] = 4'($urandom_range(1, 15));
      endcase
    end
    return v;
  endfunction

  initial begin
    bus.set_value    = 32'h0;
    bus.load_time    = 1'b0;
    bus.load_alarm   = 1'b0;
    bus.alarm_enable = 1'b0;
    bus.snooze       = 1'b0;
    bus.stop_alarm   = 1'b0;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // 23:59 rolls to midnight after one full minute
    load_t(32'h0203_0509);
    repeat (3) step();
    check("wrap_pre", bus.current_time, 32'h0203_0509);
    step();
    check("wrap_cur", bus.current_time, 32'h0);
    check("wrap_om", bus.one_minute, 1'b1);
    step();
    check("wrap_om_off", bus.one_minute, 1'b0);

    // alarm 07:00 reached from 06:59
    bus.alarm_enable = 1'b1;
    bus.set_value    = 32'h0007_0000;
    bus.load_alarm   = 1'b1;
    step();
    load_t(32'h0006_0509);
    repeat (3) step();
    check("pre_ring", bus.state, 32'd0);
    step();
    check("ring", bus.state, 32'd1);
    check("ring_snd", bus.sound_alarm, 1'b1);

    // snooze 2 minutes, then ring 3 minutes
    bus.snooze = 1'b1;
    step();
    check("snz", bus.state, 32'd2);
    repeat (6) step();
    check("snz_hold", bus.state, 32'd2);
    step();
    check("re_ring", bus.state, 32'd1);
    repeat (11) step();
    check("ring_hold", bus.state, 32'd1);
    step();
    check("auto_stop", bus.state, 32'd0);

    // snooze and stop together
    load_t(32'h0006_0509);
    repeat (4) step();
    check("ring2", bus.state, 32'd1);
    bus.snooze     = 1'b1;
    bus.stop_alarm = 1'b1;
    step();
    check("both_st", bus.state, 32'd0);
    check("both_snz", bus.snooze_active, 1'b0);

    // invalid load ignored; matching load never rings
    load_t(32'h0102_070A);
    check("bad_load", bus.current_time, to_bcd(m_min));
    load_t(32'h0007_0000);
    repeat (8) step();
    check("no_ring", bus.state, 32'd0);

    // async reset while snoozing
    load_t(32'h0006_0509);
    repeat (4) step();
    bus.snooze = 1'b1;
    step();
    check("pre_rst", bus.state, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_cur", bus.current_time, 32'h0);
    check("rst_alm", bus.alarm_time, 32'h0);
    check("rst_st", bus.state, 32'd0);
    check("rst_snz", bus.snooze_active, 1'b0);
    check("rst_snd", bus.sound_alarm, 1'b0);
    check("rst_om", bus.one_minute, 1'b0);
    #4 rst_n = 1'b1;
    repeat (8) step();

    // random commands
    for (int c = 0; c < 3000; c++) begin
      bus.alarm_enable = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 99) < 3) begin
        bus.set_value = rand_val();
        bus.load_time = 1'b1;
      end
      if ($urandom_range(0, 99) < 3) begin
        if (!bus.load_time) begin
          if ($urandom_range(0, 1) == 1)
            bus.set_value =
              to_bcd((m_min + $urandom_range(1, 3)) % 1440);
          else
            bus.set_value = rand_val();
        end
        bus.load_alarm = 1'b1;
      end
      bus.snooze     = ($urandom_range(0, 99) < 8);
      bus.stop_alarm = ($urandom_range(0, 99) < 3);
      step();
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
